// File: rtl/sub_shift_engine_if.sv
// rtl/sub_shift_engine_if.sv - handshake bundle between upstream, engine and MixColumns
interface sub_shift_engine_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic         out_err;
  logic [15:0]  out_err_mask;

  // Upstream/downstream side (drives offers and accepts results)
  modport master (
    output in_valid, in_state, out_ready,
    input  in_ready, out_valid, out_state, out_err, out_err_mask
  );

  // Engine side
  modport slave (
    input  in_valid, in_state, out_ready,
    output in_ready, out_valid, out_state, out_err, out_err_mask
  );
endinterface

// File: rtl/sub_shift_engine.sv
// rtl/sub_shift_engine.sv - byte-serial AES SubBytes + ShiftRows stage with error flags
module sub_shift_engine #(
  parameter int LANES = 1
) (
  input logic               clk,
  input logic               rst,
  sub_shift_engine_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Counter value at which the final group of LANES bytes is processed
  localparam logic [3:0] LAST_CNT = 4'(16 - LANES);

  // GF(2^8) doubling modulo the AES polynomial
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 = a^2 * a^4 * ... * a^128; zero maps to zero
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] sq;
    r  = 8'h01;
    sq = a;
    for (int k = 1; k < 8; k++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  // Concurrent check: undo the affine map on the output and confirm it is
  // the field inverse of the input (x * y == 1, or both zero).
  function automatic logic sbox_check(input logic [7:0] x, input logic [7:0] s);
    logic [7:0] y;
    y = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    if (x == 8'h00) return (y != 8'h00);
    return (gf_mul(x, y) != 8'h01);
  endfunction

  state_t       state_q, state_d;
  logic [127:0] src_q, src_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [127:0] out_state_q, out_state_d;
  logic [15:0]  mask_q, mask_d;
  logic         err_q, err_d;

  logic [LANES-1:0][3:0] lane_idx;
  logic [LANES-1:0][3:0] dest_idx;
  logic [LANES-1:0][7:0] lane_in;
  logic [LANES-1:0][7:0] lane_out;
  logic [LANES-1:0]      unit_err;

  logic accept;
  logic last_grp;

  assign accept   = (state_q == IDLE) && bus.in_valid;
  assign last_grp = (cnt_q == LAST_CNT);

  // Byte units: lane l handles input byte cnt+l (row = idx%4, col = idx/4)
  // and targets output column (col - row) mod 4 in the same row.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign lane_idx[l] = cnt_q + 4'(l);
    assign dest_idx[l] = {lane_idx[l][3:2] - lane_idx[l][1:0], lane_idx[l][1:0]};
    assign lane_in[l]  = src_q[{~lane_idx[l], 3'b000} +: 8];
    assign lane_out[l] = sbox(lane_in[l]);
    assign unit_err[l] = sbox_check(lane_in[l], lane_out[l]);
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state: accept in IDLE, step groups in RUN, wait for drain in DONE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid)  state_d = RUN;
      RUN:     if (last_grp)      state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: only one block in flight, so handshakes map directly to state
  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == DONE);
  end

  // Datapath next-state: latch on accept, scatter substituted bytes during RUN
  always_comb begin
    src_d       = src_q;
    cnt_d       = cnt_q;
    out_state_d = out_state_q;
    mask_d      = mask_q;
    if (accept) begin
      src_d  = bus.in_state;
      cnt_d  = 4'd0;
      mask_d = 16'h0000;
    end else if (state_q == RUN) begin
      for (int l = 0; l < LANES; l++) begin
        out_state_d[{~dest_idx[l], 3'b000} +: 8] = lane_out[l];
        mask_d[lane_idx[l]]                       = unit_err[l];
      end
      cnt_d = cnt_q + 4'(LANES);
    end
    err_d = |mask_d;
  end

  // Datapath registers; reset discards any partially processed block
  always_ff @(posedge clk) begin
    if (rst) begin
      src_q       <= '0;
      cnt_q       <= '0;
      out_state_q <= '0;
      mask_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      src_q       <= src_d;
      cnt_q       <= cnt_d;
      out_state_q <= out_state_d;
      mask_q      <= mask_d;
      err_q       <= err_d;
    end
  end

  assign bus.out_state    = out_state_q;
  assign bus.out_err_mask = mask_q;
  assign bus.out_err      = err_q;

endmodule

// File: tb/tb_sub_shift_engine.sv
// tb/tb_sub_shift_engine.sv - directed self-checking bench for sub_shift_engine
module tb_sub_shift_engine;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  localparam logic [127:0] V0_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] V0_OUT = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [127:0] V1_IN  = 128'ha49c7ff2689f352b6b5bea43026a5049;
  localparam logic [127:0] V1_OUT = 128'h49db873b453953897f02d2f177de961a;
  localparam logic [127:0] V2_IN  = 128'haa8f5f0361dde3ef82d24ad26832469a;
  localparam logic [127:0] V2_OUT = 128'hacc1d6b8efb55a7b1323cfdf457311b5;
  localparam logic [127:0] ZERO_OUT = {16{8'h63}};

  sub_shift_engine_if if1 ();
  sub_shift_engine_if if4 ();

  sub_shift_engine #(.LANES(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
  sub_shift_engine #(.LANES(4)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    if1.in_valid = 1'b0; if1.in_state = '0; if1.out_ready = 1'b0;
    if4.in_valid = 1'b0; if4.in_state = '0; if4.out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    checks++; if (if1.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", if1.in_ready); end
    checks++; if (if1.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", if1.out_valid); end
    checks++; if (if1.out_state !== 128'h0) begin errors++; $display("FAIL reset_out_state: got %h expected 0", if1.out_state); end
    checks++; if (if1.out_err_mask !== 16'h0) begin errors++; $display("FAIL reset_mask: got %h expected 0000", if1.out_err_mask); end
    checks++; if (if1.out_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", if1.out_err); end
    checks++; if (if4.in_ready !== 1'b1 || if4.out_valid !== 1'b0) begin errors++; $display("FAIL reset_lanes4_hs: got ready=%b valid=%b expected 1/0", if4.in_ready, if4.out_valid); end
  endtask

  task automatic test_lanes1_vector();
    int cyc;
    if1.out_ready = 1'b0;
    if1.in_state = V0_IN; if1.in_valid = 1'b1;
    tick();
    if1.in_valid = 1'b0;
    cyc = 0;
    while (if1.out_valid !== 1'b1 && cyc < 64) begin tick(); cyc++; end
    checks++; if (cyc != 16) begin errors++; $display("FAIL l1_latency: got %0d expected 16", cyc); end
    checks++; if (if1.out_state !== V0_OUT) begin errors++; $display("FAIL l1_state: got %h expected %h", if1.out_state, V0_OUT); end
    checks++; if (if1.out_err_mask !== 16'h0 || if1.out_err !== 1'b0) begin errors++; $display("FAIL l1_err: got mask=%h err=%b expected 0000/0", if1.out_err_mask, if1.out_err); end
    if1.out_ready = 1'b1;
    tick();
    if1.out_ready = 1'b0;
    checks++; if (if1.in_ready !== 1'b1 || if1.out_valid !== 1'b0) begin errors++; $display("FAIL l1_release: got ready=%b valid=%b expected 1/0", if1.in_ready, if1.out_valid); end
  endtask

  task automatic test_lanes4();
    int cyc;
    int busy_bad;
    if4.out_ready = 1'b0;
    if4.in_state = '0; if4.in_valid = 1'b1;
    tick();
    if4.in_valid = 1'b0;
    cyc = 0; busy_bad = 0;
    while (if4.out_valid !== 1'b1 && cyc < 64) begin
      if (if4.in_ready !== 1'b0) busy_bad++;
      tick(); cyc++;
    end
    if (if4.in_ready !== 1'b0) busy_bad++;
    checks++; if (cyc != 4) begin errors++; $display("FAIL l4_latency: got %0d expected 4", cyc); end
    checks++; if (busy_bad != 0) begin errors++; $display("FAIL l4_in_ready_low: got %0d cycles high expected 0", busy_bad); end
    checks++; if (if4.out_state !== ZERO_OUT) begin errors++; $display("FAIL l4_zero_state: got %h expected %h", if4.out_state, ZERO_OUT); end
    if4.out_ready = 1'b1;
    tick();
    if4.out_ready = 1'b0;
    if4.in_state = V0_IN; if4.in_valid = 1'b1;
    tick();
    if4.in_valid = 1'b0;
    cyc = 0;
    while (if4.out_valid !== 1'b1 && cyc < 64) begin tick(); cyc++; end
    checks++; if (cyc != 4) begin errors++; $display("FAIL l4_vec_latency: got %0d expected 4", cyc); end
    checks++; if (if4.out_state !== V0_OUT) begin errors++; $display("FAIL l4_vec_state: got %h expected %h", if4.out_state, V0_OUT); end
    checks++; if (if4.out_err_mask !== 16'h0) begin errors++; $display("FAIL l4_vec_mask: got %h expected 0000", if4.out_err_mask); end
    if4.out_ready = 1'b1;
    tick();
    if4.out_ready = 1'b0;
  endtask

  task automatic test_error_inject();
    int cyc;
    if1.out_ready = 1'b0;
    if1.in_state = V0_IN; if1.in_valid = 1'b1;
    tick();
    if1.in_valid = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    force dut1.unit_err = 1'b1;
    tick();
    release dut1.unit_err;
    cyc = 0;
    while (if1.out_valid !== 1'b1 && cyc < 64) begin tick(); cyc++; end
    checks++; if (cyc != 10) begin errors++; $display("FAIL inj_latency: got %0d expected 10", cyc); end
    checks++; if (if1.out_err_mask !== 16'h0020) begin errors++; $display("FAIL inj_mask: got %h expected 0020", if1.out_err_mask); end
    checks++; if (if1.out_err !== 1'b1) begin errors++; $display("FAIL inj_err: got %b expected 1", if1.out_err); end
    checks++; if (if1.out_state !== V0_OUT) begin errors++; $display("FAIL inj_state: got %h expected %h", if1.out_state, V0_OUT); end
    if1.out_ready = 1'b1;
    tick();
    if1.out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int cyc;
    int bad;
    if1.out_ready = 1'b0;
    if1.in_state = V1_IN; if1.in_valid = 1'b1;
    tick();
    if1.in_valid = 1'b0;
    cyc = 0;
    while (if1.out_valid !== 1'b1 && cyc < 64) begin tick(); cyc++; end
    checks++; if (if1.out_state !== V1_OUT) begin errors++; $display("FAIL bp_state: got %h expected %h", if1.out_state, V1_OUT); end
    if1.in_state = V2_IN; if1.in_valid = 1'b1;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (if1.out_valid !== 1'b1 || if1.out_state !== V1_OUT || if1.out_err_mask !== 16'h0 || if1.in_ready !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL bp_hold: got %0d unstable cycles expected 0", bad); end
    if1.out_ready = 1'b1;
    tick();
    if1.out_ready = 1'b0;
    checks++; if (if1.in_ready !== 1'b1 || if1.out_valid !== 1'b0) begin errors++; $display("FAIL bp_release: got ready=%b valid=%b expected 1/0", if1.in_ready, if1.out_valid); end
    tick();
    if1.in_valid = 1'b0;
    checks++; if (if1.in_ready !== 1'b0) begin errors++; $display("FAIL bp_second_accept: got ready=%b expected 0", if1.in_ready); end
    cyc = 0;
    while (if1.out_valid !== 1'b1 && cyc < 64) begin tick(); cyc++; end
    checks++; if (cyc != 16) begin errors++; $display("FAIL bp_second_latency: got %0d expected 16", cyc); end
    checks++; if (if1.out_state !== V2_OUT) begin errors++; $display("FAIL bp_second_state: got %h expected %h", if1.out_state, V2_OUT); end
    if1.out_ready = 1'b1;
    tick();
    if1.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    int cyc;
    if1.out_ready = 1'b0;
    if1.in_state = V0_IN; if1.in_valid = 1'b1;
    tick();
    if1.in_valid = 1'b0;
    for (int k = 0; k < 7; k++) tick();
    rst = 1'b1;
    tick();
    checks++; if (if1.in_ready !== 1'b1 || if1.out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_hs: got ready=%b valid=%b expected 1/0", if1.in_ready, if1.out_valid); end
    checks++; if (if1.out_state !== 128'h0 || if1.out_err_mask !== 16'h0) begin errors++; $display("FAIL mid_rst_regs: got state=%h mask=%h expected 0/0", if1.out_state, if1.out_err_mask); end
    if1.in_state = V1_IN; if1.in_valid = 1'b1;
    tick();
    checks++; if (if1.in_ready !== 1'b1) begin errors++; $display("FAIL rst_beats_hs: got ready=%b expected 1", if1.in_ready); end
    rst = 1'b0;
    if1.in_state = V0_IN;
    tick();
    if1.in_valid = 1'b0;
    cyc = 0;
    while (if1.out_valid !== 1'b1 && cyc < 64) begin tick(); cyc++; end
    checks++; if (cyc != 16) begin errors++; $display("FAIL post_rst_latency: got %0d expected 16", cyc); end
    checks++; if (if1.out_state !== V0_OUT) begin errors++; $display("FAIL post_rst_state: got %h expected %h", if1.out_state, V0_OUT); end
    if1.out_ready = 1'b1;
    tick();
    if1.out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [127:0] vin [3];
    logic [127:0] vout [3];
    int sent;
    int got;
    int cyc;
    int last_acc;
    logic acc;
    vin[0] = V1_IN; vout[0] = V1_OUT;
    vin[1] = V2_IN; vout[1] = V2_OUT;
    vin[2] = V0_IN; vout[2] = V0_OUT;
    sent = 0; got = 0; cyc = 0; last_acc = 0;
    if1.out_ready = 1'b1;
    if1.in_state = vin[0]; if1.in_valid = 1'b1;
    while (got < 3 && cyc < 200) begin
      if (if1.out_valid === 1'b1) begin
        checks++; if (if1.out_state !== vout[got]) begin errors++; $display("FAIL b2b_state%0d: got %h expected %h", got, if1.out_state, vout[got]); end
        got++;
      end
      acc = if1.in_valid && if1.in_ready;
      tick(); cyc++;
      if (acc) begin
        if (sent > 0) begin
          checks++; if (cyc - last_acc != 18) begin errors++; $display("FAIL b2b_period: got %0d expected 18", cyc - last_acc); end
        end
        last_acc = cyc;
        sent++;
        if (sent < 3) if1.in_state = vin[sent];
        else          if1.in_valid = 1'b0;
      end
    end
    checks++; if (got != 3) begin errors++; $display("FAIL b2b_count: got %0d expected 3", got); end
    if1.in_valid = 1'b0;
    if1.out_ready = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_lanes1_vector();
    test_lanes4();
    test_error_inject();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sub_shift_engine.md
# sub_shift_engine

Byte-serial AES SubBytes + ShiftRows stage for one 128-bit state. It sits directly downstream of the round-key-add logic. It streams the state through LANES instances of the existing combinational SubBytes byte unit (8-bit in, 8-bit out, 1-bit error), places each substituted byte at its ShiftRows position, and collects the per-byte concurrent-error flags. The result goes to MixColumns over a valid/ready handshake.

## Interface
- LANES, 1, byte units used per cycle; legal values 1, 2, 4, 8, 16; N = 16/LANES processing cycles per block
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  upstream offers in_state
- in_ready  out  1  block can accept a state
- in_state  in  128  input state; byte i = in_state[127-8i -: 8]; byte i is at row i%4, column i/4
- out_valid  out  1  out_state/out_err/out_err_mask are valid
- out_ready  in  1  downstream accepts
- out_state  out  128  SubBytes+ShiftRows result, same byte ordering as in_state
- out_err  out  1  OR of out_err_mask
- out_err_mask  out  16  bit i = byte unit flagged an error while substituting input byte i

## Operation
- FSM states:
  - IDLE: in_ready=1, out_valid=0.
    - On in_valid&&in_ready: latch in_state, clear the work registers, clear cnt to 0, go to RUN.
  - RUN: in_ready=0, out_valid=0.
    - Each cycle, LANES units process input bytes cnt..cnt+LANES-1.
    - Input byte i = r+4c is substituted and written to output position r+4((c-r) mod 4).
    - Its error bit is written to mask bit i.
    - cnt += LANES. On the cycle processing the last group (cnt = 16-LANES), go to DONE.
  - DONE: out_valid=1, in_ready=0.
    - On out_ready, go to IDLE.
- cnt is 4 bits wide. It never wraps within a block because the DONE transition happens first.
- out_state, out_err_mask and out_err are registered. They hold stable while out_valid=1 and out_ready=0.
- Output registers are not cleared on return to IDLE; they are only overwritten by the next RUN.
- in_valid and in_state are ignored while in_ready=0.
- A detected error does not abort processing. The block always completes and the flags travel with the data.
- No pass-through: a new block is accepted only in IDLE, so at most one block is in flight.

## Timing
- Reset values (on any cycle, including mid-RUN or mid-DONE):
  - state=IDLE, in_ready=1, out_valid=0
  - out_state=0, out_err_mask=0, out_err=0, cnt=0
  - any partially processed block is discarded
- Latency: input handshake at edge E. out_valid is high from edge E+N.
- in_ready returns high on the edge after the output handshake edge.
- Minimum block period is N+2 cycles (IDLE accept, N RUN cycles, 1 DONE cycle) with out_ready tied high.
- A simultaneous rst and handshake in the same cycle is ignored; rst wins.
- out_ready while out_valid=0 has no effect.

## Test plan
- LANES=1, in_state=193de3bea0f4e22b9ac68d2ae9f84808 -> out_valid at E+16, out_state=d4bf5d30e0b452aeb84111f11e2798e5, out_err_mask=0000, out_err=0.
- LANES=4, in_state all zero -> out_state=63 repeated 16 times at E+4; in_ready low for cycles E+1..E+4.
- LANES=1, force the byte unit error output to 1 only while input byte 5 is processed -> out_err_mask=0020, out_err=1, out_state unaffected by the error flag.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid. Outputs stay stable, in_ready stays 0, and a second in_valid offer is not accepted until one cycle after out_ready is raised.
- Assert rst at RUN cycle 7 (LANES=1) -> next cycle in_ready=1, out_valid=0, out_state=0. A fresh block then completes correctly in 16 cycles.
- Back-to-back: in_valid and out_ready held high with 3 random states -> each output is correct, and consecutive in-handshakes are exactly N+2 cycles apart.
